fir_axil_cfg: RTL and testbench
===============================

# fir_axil_cfg

AXI4-Lite configuration slave for the FIR accelerator. It supports independent AW/W acceptance, a B response channel, byte strobes, and latency-correct reads from the tap BRAM. It owns the ap_ctrl (ap_start/ap_done/ap_idle) and data_length registers, guards tap accesses while the engine runs, and drives the start/done handshake to the FIR datapath. It sits between the host AXI4-Lite bus and the tap RAM/FIR engine core.

## Interface
- pADDR_WIDTH, 12, AXI-Lite address width (byte addresses)
- pDATA_WIDTH, 32, data width; fixed at 32
- pTAP_NUM, 11, number of taps, legal range 1..16
- axis_clk  in  1  sole clock
- axis_rst  in  1  asynchronous active-high reset
- awaddr/awvalid/awready  in/in/out  pADDR_WIDTH/1/1  write address channel
- wdata/wstrb/wvalid/wready  in/in/in/out  32/4/1/1  write data channel
- bresp/bvalid/bready  out/out/in  2/1/1  write response; OKAY=2'b00, SLVERR=2'b10
- araddr/arvalid/arready  in/in/out  pADDR_WIDTH/1/1  read address channel
- rdata/rresp/rvalid/rready  out/out/out/in  32/2/1/1  read data channel
- tap_WE/tap_EN/tap_Di/tap_A  out  4/1/32/pADDR_WIDTH  tap BRAM port; tap_Do is valid one cycle after tap_EN
- tap_Do  in  32  tap BRAM read data
- ap_start_o  out  1  one-cycle start pulse to the engine
- eng_done_i  in  1  one-cycle done pulse from the engine
- data_length_o  out  32  data_length register value

## Operation
- Address map:
  - 0x00 ap_ctrl: bit0 ap_start, bit1 ap_done, bit2 ap_idle; all other bits read 0.
  - 0x10 data_length: read/write, honours wstrb.
  - 0x40+4*i, i<pTAP_NUM: tap i.
  - Any other address gives SLVERR; writes have no effect and reads return 0.
- Reset values:
  - ap_idle=1; ap_start=ap_done=0; data_length=0.
  - All ready/valid outputs 0; bresp=rresp=0; rdata=0; tap_WE=0, tap_EN=0, tap_A=0, tap_Di=0.
- Write FSM (W_IDLE, W_EXEC, W_RESP):
  - AW and W are captured independently into holding registers. awready is high while its holding register is empty and state is W_IDLE; wready follows the same rule for W.
  - When both holding registers are full, go to W_EXEC for one cycle to perform the write, then go to W_RESP with bvalid=1.
  - bvalid is held until bready. On the handshake, the holding registers clear and the FSM returns to W_IDLE.
- Tap write: tap_EN=1, tap_WE=wstrb, tap_A={i,2'b00}, tap_Di=wdata.
  - If ap_idle=0, the write is dropped and bresp=SLVERR.
- ap_ctrl write with wdata[0]=1 and wstrb[0]=1 while ap_idle=1:
  - ap_start=1 for exactly one cycle, equal to ap_start_o; ap_idle clears in the same cycle.
  - The same write while ap_idle=0 is ignored, with bresp=OKAY.
- Read FSM (R_IDLE, R_ISSUE, R_DATA):
  - arready=1 only in R_IDLE; an AR handshake goes to R_ISSUE.
  - In R_ISSUE, a tap target drives tap_EN=1, tap_A={i,2'b00}.
  - In R_DATA, rvalid=1 and rdata holds stably until rready. The rready handshake returns to R_IDLE.
  - A tap read while ap_idle=0 gives rresp=SLVERR, rdata=0, and no BRAM access.
- Tap port conflict: if W_EXEC and R_ISSUE both target the tap RAM in the same cycle, the write wins and R_ISSUE stalls one cycle.
- eng_done_i sets ap_done=1 and ap_idle=1.
- Reading ap_ctrl clears ap_done on the R handshake. If eng_done_i coincides with that handshake, the set wins and ap_done stays 1.

## Timing
- Write: AW and W both handshaken by cycle T; tap_WE or register update at T+1; bvalid at T+2.
- Read: AR handshake at T; tap_EN at T+1 (T+2 if stalled); rvalid at T+2 (T+3 if stalled).
- ap_ctrl write executed at T: ap_start_o=1 and ap_idle=0 at T+1, ap_start_o=0 at T+2.
- Reset asserted mid-transaction: all state, holding registers, bvalid and rvalid return to reset values asynchronously. Partial transactions are discarded.

## Structure
- fir_cfg_pkg holds:
  - address constants ADDR_AP_CTRL, ADDR_DATA_LEN, ADDR_TAP_BASE
  - ap_ctrl bit indices
  - RESP_OKAY, RESP_SLVERR
  - write and read FSM state encodings
- One sub-module, axil_hold_reg, is instantiated for AW and for W: a one-entry holding register with valid/ready and a clear input.

## Test plan
- Reset: after axis_rst, reading 0x00 -> rdata=0x4, rresp=OKAY; reading 0x10 -> 0.
- W before AW: wvalid with 0x12345678 at cycle 0, awvalid 0x48 at cycle 3 -> a single tap_WE=4'hF, tap_A=0x008, tap_Di=0x12345678; bresp=OKAY. Reading 0x48 -> 0x12345678 with rvalid 2 cycles after AR.
- Strobes: write 0x10 = 0xAABBCCDD with wstrb=4'b0011 over 0 -> data_length_o=0x0000CCDD.
- Start/done: write 0x00 = 0x1 -> a one-cycle ap_start_o pulse and ap_ctrl reads 0x0. Then:
  - a tap write returns bresp=SLVERR with no tap_WE;
  - pulse eng_done_i -> ap_ctrl reads 0x6, a second read returns 0x4.
- Error and back-pressure: read 0x2C -> rresp=SLVERR, rdata=0. Hold bready=0 for 5 cycles -> bvalid stays 1 and awready stays 0.
- Conflict and reset: a tap read and a tap write issued at the same cycle -> the write completes first and the read returns the new value. axis_rst during R_DATA -> rvalid drops immediately.

Source files
------------

// File: rtl/fir_cfg_pkg.sv
// Shared constants, FSM encodings and address decode for the FIR AXI4-Lite config slave.
package fir_cfg_pkg;
  localparam logic [31:0] ADDR_AP_CTRL  = 32'h0000_0000;
  localparam logic [31:0] ADDR_DATA_LEN = 32'h0000_0010;
  localparam logic [31:0] ADDR_TAP_BASE = 32'h0000_0040;

  localparam int AP_START = 0;
  localparam int AP_DONE  = 1;
  localparam int AP_IDLE  = 2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_EXEC = 2'd1, W_RESP = 2'd2} w_state_e;
  typedef enum logic [1:0] {R_IDLE = 2'd0, R_ISSUE = 2'd1, R_DATA = 2'd2} r_state_e;

  typedef struct packed {
    logic       ctrl;
    logic       dlen;
    logic       tap;
    logic [3:0] idx;
  } addr_dec_t;

  // Tap slots must be word aligned; unaligned tap-window addresses decode as unmapped.
  function automatic addr_dec_t decode(input logic [31:0] a, input int unsigned ntap);
    logic [31:0] off;
    addr_dec_t   d;
    off    = a - ADDR_TAP_BASE;
    d.ctrl = (a == ADDR_AP_CTRL);
    d.dlen = (a == ADDR_DATA_LEN);
    d.tap  = (a >= ADDR_TAP_BASE) && (off[1:0] == 2'b00) && ({2'b00, off[31:2]} < ntap);
    d.idx  = off[5:2];
    return d;
  endfunction
endpackage

// File: rtl/axil_hold_reg.sv
// One-entry holding register for an AXI-Lite channel, cleared when the transaction retires.
module axil_hold_reg #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  input  logic         clr_i,
  input  logic         valid_i,
  input  logic [W-1:0] data_i,
  output logic         ready_o,
  output logic         full_o,
  output logic [W-1:0] data_o
);
  logic         full_q;
  logic [W-1:0] data_q;

  assign ready_o = en_i && !full_q;
  assign full_o  = full_q;
  assign data_o  = data_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else if (clr_i) begin
      full_q <= 1'b0;
    end else if (valid_i && ready_o) begin
      full_q <= 1'b1;
      data_q <= data_i;
    end
  end
endmodule

// File: rtl/fir_axil_cfg.sv
// AXI4-Lite config slave for the FIR engine: ap_ctrl, data_length and guarded tap RAM access.
module fir_axil_cfg
  import fir_cfg_pkg::*;
#(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int pTAP_NUM    = 11
) (
  input  logic                     axis_clk,
  input  logic                     axis_rst,
  input  logic [pADDR_WIDTH-1:0]   awaddr,
  input  logic                     awvalid,
  output logic                     awready,
  input  logic [pDATA_WIDTH-1:0]   wdata,
  input  logic [pDATA_WIDTH/8-1:0] wstrb,
  input  logic                     wvalid,
  output logic                     wready,
  output logic [1:0]               bresp,
  output logic                     bvalid,
  input  logic                     bready,
  input  logic [pADDR_WIDTH-1:0]   araddr,
  input  logic                     arvalid,
  output logic                     arready,
  output logic [pDATA_WIDTH-1:0]   rdata,
  output logic [1:0]               rresp,
  output logic                     rvalid,
  input  logic                     rready,
  output logic [3:0]               tap_WE,
  output logic                     tap_EN,
  output logic [pDATA_WIDTH-1:0]   tap_Di,
  output logic [pADDR_WIDTH-1:0]   tap_A,
  input  logic [pDATA_WIDTH-1:0]   tap_Do,
  output logic                     ap_start_o,
  input  logic                     eng_done_i,
  output logic [pDATA_WIDTH-1:0]   data_length_o
);
  localparam int STRB_W = pDATA_WIDTH / 8;

  w_state_e w_state_q, w_state_d;
  r_state_e r_state_q, r_state_d;

  logic                   live_q, hold_en, hold_clr;
  logic                   aw_full, w_full;
  logic [pADDR_WIDTH-1:0] aw_q, ar_addr_q;
  logic [pDATA_WIDTH+STRB_W-1:0] w_q;
  logic [pDATA_WIDTH-1:0] w_data, dlen_q, rdata_q, r_val;
  logic [STRB_W-1:0]      w_strb;
  logic [1:0]             bresp_q, rresp_q;
  logic                   r_live_q, ap_start_q, ap_done_q, ap_idle_q;
  addr_dec_t              wdec, rdec;
  logic                   w_exec, w_err, w_tap_go, start_go;
  logic                   r_issue, r_stall, r_err, r_tap_go;

  axil_hold_reg #(.W(pADDR_WIDTH)) u_aw_hold (
    .clk_i(axis_clk), .rst_i(axis_rst), .en_i(hold_en), .clr_i(hold_clr),
    .valid_i(awvalid), .data_i(awaddr), .ready_o(awready), .full_o(aw_full), .data_o(aw_q)
  );

  axil_hold_reg #(.W(pDATA_WIDTH + STRB_W)) u_w_hold (
    .clk_i(axis_clk), .rst_i(axis_rst), .en_i(hold_en), .clr_i(hold_clr),
    .valid_i(wvalid), .data_i({wstrb, wdata}), .ready_o(wready), .full_o(w_full), .data_o(w_q)
  );

  assign w_data = w_q[pDATA_WIDTH-1:0];
  assign w_strb = w_q[pDATA_WIDTH +: STRB_W];
  assign wdec   = decode(32'(aw_q), pTAP_NUM);
  assign rdec   = decode(32'(ar_addr_q), pTAP_NUM);

  assign w_exec   = (w_state_q == W_EXEC);
  assign w_tap_go = w_exec && wdec.tap && ap_idle_q;
  assign w_err    = !(wdec.ctrl || wdec.dlen || wdec.tap) || (wdec.tap && !ap_idle_q);
  assign start_go = w_exec && wdec.ctrl && w_strb[0] && w_data[0] && ap_idle_q;

  // Single-ported tap RAM: a same-cycle tap write takes the port, the read retries next cycle.
  assign r_issue  = (r_state_q == R_ISSUE);
  assign r_stall  = r_issue && rdec.tap && w_tap_go;
  assign r_err    = !(rdec.ctrl || rdec.dlen || rdec.tap) || (rdec.tap && !ap_idle_q);
  assign r_tap_go = r_issue && !r_stall && rdec.tap && ap_idle_q;

  always_comb begin
    r_val = '0;
    if (rdec.ctrl) begin
      r_val[AP_START] = ap_start_q;
      r_val[AP_DONE]  = ap_done_q;
      r_val[AP_IDLE]  = ap_idle_q;
    end else if (rdec.dlen) begin
      r_val = dlen_q;
    end
  end

  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
    end
  end

  // Enter W_EXEC on the edge the second channel handshakes, so the write lands at T+1.
  always_comb begin
    w_state_d = w_state_q;
    case (w_state_q)
      W_IDLE: if ((aw_full || (awvalid && awready)) && (w_full || (wvalid && wready)))
                w_state_d = W_EXEC;
      W_EXEC: w_state_d = W_RESP;
      W_RESP: if (bready) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    case (r_state_q)
      R_IDLE:  if (arvalid && arready) r_state_d = R_ISSUE;
      R_ISSUE: if (!r_stall) r_state_d = R_DATA;
      R_DATA:  if (rready) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    hold_en  = live_q && (w_state_q == W_IDLE);
    hold_clr = (w_state_q == W_RESP) && bready;
    bvalid   = (w_state_q == W_RESP);
    arready  = live_q && (r_state_q == R_IDLE);
    rvalid   = (r_state_q == R_DATA);
    tap_EN   = w_tap_go || r_tap_go;
    tap_WE   = w_tap_go ? w_strb : 4'b0000;
    tap_Di   = w_tap_go ? w_data : '0;
    tap_A    = w_tap_go ? pADDR_WIDTH'({wdec.idx, 2'b00}) :
               r_tap_go ? pADDR_WIDTH'({rdec.idx, 2'b00}) : '0;
  end

  assign bresp         = bresp_q;
  assign rresp         = rresp_q;
  assign rdata         = r_live_q ? tap_Do : rdata_q;
  assign ap_start_o    = ap_start_q;
  assign data_length_o = dlen_q;

  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      live_q     <= 1'b0;
      ar_addr_q  <= '0;
      bresp_q    <= RESP_OKAY;
      rresp_q    <= RESP_OKAY;
      rdata_q    <= '0;
      r_live_q   <= 1'b0;
      dlen_q     <= '0;
      ap_start_q <= 1'b0;
      ap_done_q  <= 1'b0;
      ap_idle_q  <= 1'b1;
    end else begin
      live_q     <= 1'b1;
      ap_start_q <= start_go;
      if (arvalid && arready) ar_addr_q <= araddr;
      if (w_exec) begin
        bresp_q <= w_err ? RESP_SLVERR : RESP_OKAY;
        if (wdec.dlen)
          for (int b = 0; b < STRB_W; b++)
            if (w_strb[b]) dlen_q[8*b +: 8] <= w_data[8*b +: 8];
      end
      // Tap data is live for one cycle only; capture it so rdata holds under back-pressure.
      if (r_issue && !r_stall) begin
        rresp_q  <= r_err ? RESP_SLVERR : RESP_OKAY;
        rdata_q  <= r_err ? '0 : r_val;
        r_live_q <= r_tap_go;
      end else if (rvalid && r_live_q) begin
        rdata_q  <= tap_Do;
        r_live_q <= 1'b0;
      end
      if (start_go) ap_idle_q <= 1'b0;
      if (eng_done_i) begin
        ap_done_q <= 1'b1;
        ap_idle_q <= 1'b1;
      end else if (rvalid && rready && rdec.ctrl) begin
        ap_done_q <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_fir_axil_cfg.sv
// Directed bench for fir_axil_cfg with a registered tap BRAM model.
module tb_fir_axil_cfg;
  logic        axis_clk = 1'b0;
  logic        axis_rst = 1'b1;
  logic [11:0] awaddr = '0, araddr = '0, tap_A;
  logic        awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0, eng_done_i = 0;
  logic        awready, wready, bvalid, arready, rvalid, tap_EN, ap_start_o;
  logic [31:0] wdata = '0, rdata, tap_Di, tap_Do, data_length_o;
  logic [3:0]  wstrb = '0, tap_WE;
  logic [1:0]  bresp, rresp;

  int errors = 0, checks = 0;
  int wr_cnt = 0, en_cnt = 0, start_cnt = 0;
  logic [11:0] last_A = '0;
  logic [31:0] last_Di = '0;
  logic [3:0]  last_WE = '0;
  logic [31:0] tmem [16] = '{default: 32'h0};

  always #5 axis_clk = ~axis_clk;

  fir_axil_cfg dut (
    .axis_clk(axis_clk), .axis_rst(axis_rst),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .tap_WE(tap_WE), .tap_EN(tap_EN), .tap_Di(tap_Di), .tap_A(tap_A), .tap_Do(tap_Do),
    .ap_start_o(ap_start_o), .eng_done_i(eng_done_i), .data_length_o(data_length_o)
  );

  // BRAM model: data valid only in the cycle after tap_EN, garbage otherwise.
  always @(posedge axis_clk) begin
    if (tap_EN) begin
      tap_Do <= tmem[tap_A[5:2]];
      for (int b = 0; b < 4; b++)
        if (tap_WE[b]) tmem[tap_A[5:2]][8*b +: 8] <= tap_Di[8*b +: 8];
      if (tap_WE != 4'b0) begin
        wr_cnt  <= wr_cnt + 1;
        last_A  <= tap_A;
        last_Di <= tap_Di;
        last_WE <= tap_WE;
      end
      en_cnt <= en_cnt + 1;
    end else begin
      tap_Do <= 32'hDEAD_BEEF;
    end
    if (ap_start_o) start_cnt <= start_cnt + 1;
  end

  task automatic axi_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_dly, output logic [1:0] resp, output int lat);
    bit aw_done = 0, w_done = 0;
    int k = 0;
    lat = 0; resp = 2'bxx;
    awaddr = a; wdata = d; wstrb = s; wvalid = 1; awvalid = (aw_dly == 0); bready = 1;
    while (k < 60) begin
      bit aw_hs, w_hs;
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      if (bvalid) begin
        resp = bresp;
        @(posedge axis_clk); #1;
        break;
      end
      @(posedge axis_clk); #1; k++;
      if (lat > 0) lat++;
      if (aw_hs) begin awvalid = 0; aw_done = 1; end
      if (w_hs) begin wvalid = 0; w_done = 1; end
      if ((aw_hs || w_hs) && aw_done && w_done) lat = 1;
      if (!aw_done && k >= aw_dly) awvalid = 1;
    end
    awvalid = 0; wvalid = 0; bready = 0;
  endtask

  task automatic axi_read(input logic [11:0] a, input int hold, output logic [31:0] d,
                          output logic [1:0] resp, output int lat);
    bit rv_seen = 0;
    int k = 0, h = 0;
    lat = 0; d = 'x; resp = 2'bxx;
    araddr = a; arvalid = 1; rready = 0;
    while (k < 60) begin
      bit ar_hs;
      ar_hs = arvalid && arready;
      if (rvalid) begin
        rv_seen = 1;
        if (h == hold) begin
          d = rdata; resp = rresp; rready = 1;
          @(posedge axis_clk); #1;
          break;
        end
        h++;
      end
      @(posedge axis_clk); #1; k++;
      if (ar_hs) begin arvalid = 0; lat = 1; end
      else if (lat > 0 && !rv_seen) lat++;
    end
    arvalid = 0; rready = 0;
  endtask

  task automatic test_reset();
    logic [31:0] d; logic [1:0] r; int lat;
    axis_rst = 1;
    repeat (2) @(posedge axis_clk); #1;
    checks++; if ({awready, wready, arready, bvalid, rvalid} !== 5'b0) begin errors++;
      $display("FAIL reset_handshake: got %b want 00000", {awready, wready, arready, bvalid, rvalid}); end
    checks++; if ({tap_EN, tap_WE, ap_start_o, tap_A, tap_Di, rdata, bresp, rresp, data_length_o} !== '0) begin errors++;
      $display("FAIL reset_outputs: en=%b we=%h st=%b a=%h di=%h rd=%h br=%b rr=%b len=%h",
               tap_EN, tap_WE, ap_start_o, tap_A, tap_Di, rdata, bresp, rresp, data_length_o); end
    axis_rst = 0;
    @(posedge axis_clk); #1;
    axi_read(12'h000, 0, d, r, lat);
    checks++; if ({r, d} !== {2'b00, 32'h4}) begin errors++;
      $display("FAIL reset_ap_ctrl: got resp=%b data=%h want 00/00000004", r, d); end
    axi_read(12'h010, 0, d, r, lat);
    checks++; if ({r, d} !== {2'b00, 32'h0}) begin errors++;
      $display("FAIL reset_dlen: got resp=%b data=%h want 00/00000000", r, d); end
  endtask

  task automatic test_w_before_aw();
    logic [31:0] d; logic [1:0] r; int lat, w0;
    w0 = wr_cnt;
    axi_write(12'h048, 32'h1234_5678, 4'hF, 3, r, lat);
    checks++; if (r !== 2'b00 || lat != 2) begin errors++;
      $display("FAIL wfirst_resp: got resp=%b lat=%0d want 00 lat=2", r, lat); end
    checks++; if (wr_cnt - w0 != 1 || last_A !== 12'h008 || last_Di !== 32'h1234_5678 || last_WE !== 4'hF) begin errors++;
      $display("FAIL wfirst_tap: got n=%0d A=%h Di=%h WE=%h want 1/008/12345678/f", wr_cnt - w0, last_A, last_Di, last_WE); end
    axi_read(12'h048, 2, d, r, lat);
    checks++; if ({r, d} !== {2'b00, 32'h1234_5678} || lat != 2) begin errors++;
      $display("FAIL wfirst_read: got resp=%b data=%h lat=%0d want 00/12345678 lat=2", r, d, lat); end
  endtask

  task automatic test_strobe();
    logic [31:0] d; logic [1:0] r; int lat;
    axi_write(12'h010, 32'hAABB_CCDD, 4'b0011, 0, r, lat);
    checks++; if (data_length_o !== 32'h0000_CCDD || r !== 2'b00) begin errors++;
      $display("FAIL strobe_dlen: got %h resp=%b want 0000ccdd/00", data_length_o, r); end
    axi_read(12'h010, 0, d, r, lat);
    checks++; if (d !== 32'h0000_CCDD) begin errors++;
      $display("FAIL strobe_read: got %h want 0000ccdd", d); end
  endtask

  task automatic test_start_done();
    logic [31:0] d; logic [1:0] r; int lat, s0, w0, e0;
    s0 = start_cnt;
    axi_write(12'h000, 32'h1, 4'h1, 0, r, lat);
    checks++; if (start_cnt - s0 != 1 || ap_start_o !== 1'b0 || r !== 2'b00) begin errors++;
      $display("FAIL start_pulse: got pulses=%0d st=%b resp=%b want 1/0/00", start_cnt - s0, ap_start_o, r); end
    axi_read(12'h000, 0, d, r, lat);
    checks++; if (d !== 32'h0) begin errors++;
      $display("FAIL busy_ap_ctrl: got %h want 00000000", d); end
    w0 = wr_cnt;
    axi_write(12'h040, 32'h0000_FFFF, 4'hF, 0, r, lat);
    checks++; if (r !== 2'b10 || wr_cnt != w0) begin errors++;
      $display("FAIL busy_tap_write: got resp=%b writes=%0d want 10/0", r, wr_cnt - w0); end
    e0 = en_cnt;
    axi_read(12'h048, 0, d, r, lat);
    checks++; if ({r, d} !== {2'b10, 32'h0} || en_cnt != e0) begin errors++;
      $display("FAIL busy_tap_read: got resp=%b data=%h en=%0d want 10/0/0", r, d, en_cnt - e0); end
    s0 = start_cnt;
    axi_write(12'h000, 32'h1, 4'h1, 0, r, lat);
    checks++; if (start_cnt != s0 || r !== 2'b00) begin errors++;
      $display("FAIL busy_restart: got pulses=%0d resp=%b want 0/00", start_cnt - s0, r); end
    eng_done_i = 1; @(posedge axis_clk); #1; eng_done_i = 0;
    axi_read(12'h000, 0, d, r, lat);
    checks++; if (d !== 32'h6) begin errors++;
      $display("FAIL done_read1: got %h want 00000006", d); end
    axi_read(12'h000, 0, d, r, lat);
    checks++; if (d !== 32'h4) begin errors++;
      $display("FAIL done_read2: got %h want 00000004", d); end
  endtask

  task automatic test_error();
    logic [31:0] d; logic [1:0] r; int lat;
    axi_read(12'h02C, 0, d, r, lat);
    checks++; if ({r, d} !== {2'b10, 32'h0}) begin errors++;
      $display("FAIL err_read: got resp=%b data=%h want 10/0", r, d); end
    axi_write(12'h06C, 32'h1111_1111, 4'hF, 0, r, lat);
    checks++; if (r !== 2'b10) begin errors++;
      $display("FAIL err_write_tap11: got resp=%b want 10", r); end
    axi_write(12'h068, 32'hCAFE_F00D, 4'hF, 0, r, lat);
    axi_read(12'h068, 0, d, r, lat);
    checks++; if ({r, d} !== {2'b00, 32'hCAFE_F00D}) begin errors++;
      $display("FAIL last_tap: got resp=%b data=%h want 00/cafef00d", r, d); end
  endtask

  task automatic test_backpressure();
    int k = 0, bad = 0;
    awaddr = 12'h010; awvalid = 1; wdata = 32'h0102_0304; wstrb = 4'hF; wvalid = 1; bready = 0;
    @(posedge axis_clk); #1; awvalid = 0; wvalid = 0;
    while (!bvalid && k < 10) begin @(posedge axis_clk); #1; k++; end
    repeat (5) begin
      if (!(bvalid === 1'b1 && awready === 1'b0)) bad++;
      @(posedge axis_clk); #1;
    end
    checks++; if (bad != 0) begin errors++;
      $display("FAIL bp_hold: got %0d bad cycles want 0", bad); end
    checks++; if (bresp !== 2'b00 || data_length_o !== 32'h0102_0304) begin errors++;
      $display("FAIL bp_result: got resp=%b len=%h want 00/01020304", bresp, data_length_o); end
    bready = 1; @(posedge axis_clk); #1; bready = 0;
    checks++; if (bvalid !== 1'b0) begin errors++;
      $display("FAIL bp_release: got bvalid=%b want 0", bvalid); end
  endtask

  task automatic test_conflict();
    logic [31:0] d; logic [1:0] rr, br; int rl, wl;
    fork
      axi_write(12'h044, 32'h5A5A_1234, 4'hF, 0, br, wl);
      axi_read(12'h044, 0, d, rr, rl);
    join
    checks++; if (br !== 2'b00 || wl != 2) begin errors++;
      $display("FAIL conflict_write: got resp=%b lat=%0d want 00 lat=2", br, wl); end
    checks++; if ({rr, d} !== {2'b00, 32'h5A5A_1234} || rl != 3) begin errors++;
      $display("FAIL conflict_read: got resp=%b data=%h lat=%0d want 00/5a5a1234 lat=3", rr, d, rl); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d; logic [1:0] r; int lat, k = 0;
    araddr = 12'h048; arvalid = 1; rready = 0;
    while (!rvalid && k < 20) begin
      bit hs;
      hs = arvalid && arready;
      @(posedge axis_clk); #1; k++;
      if (hs) arvalid = 0;
    end
    arvalid = 0;
    checks++; if (rvalid !== 1'b1) begin errors++;
      $display("FAIL rstmid_setup: got rvalid=%b want 1", rvalid); end
    #2 axis_rst = 1;
    #1;
    checks++; if ({rvalid, bvalid, arready} !== 3'b000) begin errors++;
      $display("FAIL rstmid_drop: got rvalid/bvalid/arready=%b want 000", {rvalid, bvalid, arready}); end
    @(posedge axis_clk); #1; axis_rst = 0;
    repeat (2) @(posedge axis_clk); #1;
    checks++; if (data_length_o !== 32'h0) begin errors++;
      $display("FAIL rstmid_dlen: got %h want 0", data_length_o); end
    axi_read(12'h000, 0, d, r, lat);
    checks++; if ({r, d} !== {2'b00, 32'h4}) begin errors++;
      $display("FAIL rstmid_ap_ctrl: got resp=%b data=%h want 00/00000004", r, d); end
  endtask

  initial begin
    test_reset();
    test_w_before_aw();
    test_strobe();
    test_start_done();
    test_error();
    test_backpressure();
    test_conflict();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
